// File: rtl/sensor_request_scheduler.sv
// Sensor request scheduler: arbitrates host requests against a periodic
// auto-poll, drives a one-hot sensor enable for one access at a time, enforces
// the sensor's minimum inter-read gap and an access timeout, then emits a
// two-byte response (header, data) through the UART transmitter handshake.
module sensor_request_scheduler #(
  parameter int DEVICE_COUNT         = 32,
  parameter int MIN_GAP_CYCLES       = 100000000,
  parameter int TIMEOUT_CYCLES       = 5000000,
  parameter int POLL_INTERVAL_CYCLES = 250000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [4:0]  req_device,
  input  logic [7:0]  req_command,
  output logic        req_ready,
  input  logic        auto_enable,
  input  logic [4:0]  auto_device,
  input  logic [7:0]  auto_command,
  output logic [31:0] sensor_enable,
  output logic [7:0]  sensor_request,
  input  logic        sensor_finished,
  input  logic [7:0]  sensor_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_done
);

  // Counter widths sized to hold their terminal value; a zero-width counter
  // is avoided by clamping to one bit.
  localparam int GAP_W  = (MIN_GAP_CYCLES > 0) ? $clog2(MIN_GAP_CYCLES + 1) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int POLL_W = (POLL_INTERVAL_CYCLES > 1) ? $clog2(POLL_INTERVAL_CYCLES + 1) : 1;

  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL_CYCLES - 1);
  localparam logic [5:0]        DEV_LIMIT = 6'(DEVICE_COUNT);

  // Header status codes (upper three bits of the header byte).
  localparam logic [2:0] STAT_HOST_OK = 3'b000;
  localparam logic [2:0] STAT_AUTO_OK = 3'b001;
  localparam logic [2:0] STAT_INVALID = 3'b110;
  localparam logic [2:0] STAT_TIMEOUT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SEND_HDR,
    ST_WAIT_HDR,
    ST_SEND_DATA,
    ST_WAIT_DATA
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic               auto_pending_q, auto_pending_d;
  logic [4:0]         device_q, device_d;
  logic               is_auto_q, is_auto_d;
  logic [2:0]         status_q, status_d;
  logic [7:0]         data_q, data_d;
  logic [31:0]        sensor_enable_q, sensor_enable_d;
  logic [7:0]         sensor_request_q, sensor_request_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               ready_int;
  logic               poll_wrap;
  logic               host_accept;
  logic               auto_accept;
  logic [4:0]         sel_device;
  logic [7:0]         sel_command;
  logic               sel_valid_dev;
  logic               leave_access;

  // Host may only be accepted from IDLE once the inter-read gap has elapsed;
  // held low during reset so every output reads zero while reset_n is low.
  always_comb begin
    ready_int = (state_q == ST_IDLE) && (gap_cnt_q == '0);
  end

  assign req_ready      = ready_int & reset_n;
  assign sensor_enable  = sensor_enable_q;
  assign sensor_request = sensor_request_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;

  // Arbitration: a pending host request always beats the auto-poll; the
  // auto-poll only goes when the host line is quiet.
  always_comb begin
    poll_wrap     = auto_enable && (poll_cnt_q == POLL_LAST);
    host_accept   = 1'b0;
    auto_accept   = 1'b0;
    if (state_q == ST_IDLE) begin
      host_accept = req_valid && ready_int;
      auto_accept = !req_valid && auto_pending_q && (gap_cnt_q == '0);
    end
    sel_device    = host_accept ? req_device : auto_device;
    sel_command   = host_accept ? req_command : auto_command;
    sel_valid_dev = ({1'b0, sel_device} < DEV_LIMIT);
  end

  // Next-state logic for the scheduler FSM, gap counter and poll timer.
  always_comb begin
    state_d          = state_q;
    gap_cnt_d        = gap_cnt_q;
    tmo_cnt_d        = tmo_cnt_q;
    poll_cnt_d       = poll_cnt_q;
    auto_pending_d   = auto_pending_q;
    device_d         = device_q;
    is_auto_d        = is_auto_q;
    status_d         = status_q;
    data_d           = data_q;
    sensor_enable_d  = sensor_enable_q;
    sensor_request_d = sensor_request_q;
    tx_valid_d       = 1'b0;
    tx_data_d        = tx_data_q;
    leave_access     = 1'b0;

    // The gap counter drains in every state and saturates at zero.
    if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end

    // Poll timer: free-runs while enabled, one pending poll at most.
    if (!auto_enable) begin
      poll_cnt_d     = '0;
      auto_pending_d = 1'b0;
    end else if (poll_wrap) begin
      poll_cnt_d     = '0;
      auto_pending_d = 1'b1;
    end else begin
      poll_cnt_d = poll_cnt_q + POLL_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (host_accept || auto_accept) begin
          device_d  = sel_device;
          is_auto_d = auto_accept;
          // A poll wrapping in the same cycle starts a fresh pending poll.
          if (auto_accept && !poll_wrap) begin
            auto_pending_d = 1'b0;
          end
          if (sel_valid_dev) begin
            state_d          = ST_ACCESS;
            tmo_cnt_d        = '0;
            sensor_enable_d  = 32'd1 << sel_device;
            sensor_request_d = sel_command;
          end else begin
            // No sensor touched, so the gap is not reloaded.
            state_d  = ST_SEND_HDR;
            status_d = STAT_INVALID;
            data_d   = 8'h00;
          end
        end
      end

      ST_ACCESS: begin
        // A done strobe arriving on the last timeout cycle still counts.
        if (sensor_finished) begin
          status_d     = is_auto_q ? STAT_AUTO_OK : STAT_HOST_OK;
          data_d       = sensor_data;
          leave_access = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          status_d     = STAT_TIMEOUT;
          data_d       = 8'hFF;
          leave_access = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (leave_access) begin
          state_d          = ST_SEND_HDR;
          sensor_enable_d  = '0;
          sensor_request_d = '0;
          gap_cnt_d        = GAP_LOAD;
        end
      end

      ST_SEND_HDR: begin
        if (!tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = {status_q, device_q};
          state_d    = ST_WAIT_HDR;
        end
      end

      ST_WAIT_HDR: begin
        if (tx_done) begin
          state_d = ST_SEND_DATA;
        end
      end

      ST_SEND_DATA: begin
        if (!tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = data_q;
          state_d    = ST_WAIT_DATA;
        end
      end

      ST_WAIT_DATA: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any access or response in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      gap_cnt_q        <= '0;
      tmo_cnt_q        <= '0;
      poll_cnt_q       <= '0;
      auto_pending_q   <= 1'b0;
      device_q         <= '0;
      is_auto_q        <= 1'b0;
      status_q         <= '0;
      data_q           <= '0;
      sensor_enable_q  <= '0;
      sensor_request_q <= '0;
      tx_valid_q       <= 1'b0;
      tx_data_q        <= '0;
    end else begin
      state_q          <= state_d;
      gap_cnt_q        <= gap_cnt_d;
      tmo_cnt_q        <= tmo_cnt_d;
      poll_cnt_q       <= poll_cnt_d;
      auto_pending_q   <= auto_pending_d;
      device_q         <= device_d;
      is_auto_q        <= is_auto_d;
      status_q         <= status_d;
      data_q           <= data_d;
      sensor_enable_q  <= sensor_enable_d;
      sensor_request_q <= sensor_request_d;
      tx_valid_q       <= tx_valid_d;
      tx_data_q        <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Directed bench for sensor_request_scheduler with small timing parameters:
// gap 20, timeout 50, poll interval 200, four valid devices.
module tb_sensor_request_scheduler;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic [4:0]  req_device;
  logic [7:0]  req_command;
  logic        req_ready;
  logic        auto_enable;
  logic [4:0]  auto_device;
  logic [7:0]  auto_command;
  logic [31:0] sensor_enable;
  logic [7:0]  sensor_request;
  logic        sensor_finished;
  logic [7:0]  sensor_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sensor_request_scheduler #(
    .DEVICE_COUNT(4),
    .MIN_GAP_CYCLES(20),
    .TIMEOUT_CYCLES(50),
    .POLL_INTERVAL_CYCLES(200)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_device(req_device),
    .req_command(req_command),
    .req_ready(req_ready),
    .auto_enable(auto_enable),
    .auto_device(auto_device),
    .auto_command(auto_command),
    .sensor_enable(sensor_enable),
    .sensor_request(sensor_request),
    .sensor_finished(sensor_finished),
    .sensor_data(sensor_data),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for a tx_valid strobe, capture the byte, confirm the
  // strobe is single-cycle with data held, then acknowledge with tx_done.
  task automatic wait_tx(input int budget, output logic got, output logic [7:0] b,
                         output logic one);
    got = 1'b0;
    b   = 8'h00;
    one = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (tx_valid === 1'b1) begin
        got = 1'b1;
        b   = tx_data;
      end else begin
        tick();
      end
    end
    if (got) begin
      $display("[TB] cycle %0d tx byte %02h", cyc, b);
      tick();
      one = (tx_valid === 1'b0) && (tx_data === b);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end else begin
      $display("[TB] cycle %0d no tx byte within %0d cycles", cyc, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (sensor_enable !== 32'h0 || sensor_request !== 8'h00 || tx_valid !== 1'b0 ||
        tx_data !== 8'h00 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%08h req=%02h txv=%0b txd=%02h rdy=%0b, expected all 0",
               sensor_enable, sensor_request, tx_valid, tx_data, req_ready);
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0b expected 1", req_ready);
    end
    tick();
  endtask

  task automatic test_host_ok();
    logic got, one;
    logic [7:0] b;
    int hi;
    req_valid = 1'b1; req_device = 5'd0; req_command = 8'h01;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL host_ok_ready: got %0b expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (sensor_request !== 8'h01) begin
      n_fail++;
      $display("FAIL host_ok_cmd: got %02h expected 01", sensor_request);
    end
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (sensor_enable === 32'h1) hi++;
      if (i == 9) begin
        sensor_finished = 1'b1;
        sensor_data = 8'h1A;
      end
      tick();
    end
    sensor_finished = 1'b0;
    n_tests++;
    if (hi !== 10 || sensor_enable !== 32'h0) begin
      n_fail++;
      $display("FAIL host_ok_enable: got %0d cycles high, now %08h; expected 10 cycles, now 0",
               hi, sensor_enable);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h00 || !one) begin
      n_fail++;
      $display("FAIL host_ok_hdr: got seen=%0b byte=%02h single=%0b expected 1/00/1", got, b, one);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h1A || !one) begin
      n_fail++;
      $display("FAIL host_ok_data: got seen=%0b byte=%02h single=%0b expected 1/1a/1", got, b, one);
    end
  endtask

  task automatic test_timeout();
    logic got, one;
    logic [7:0] b;
    int hi, x, r;
    for (int i = 0; i < 40 && req_ready !== 1'b1; i++) tick();
    req_valid = 1'b1; req_device = 5'd2; req_command = 8'h02;
    tick();
    req_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 80 && sensor_enable !== 32'h0; i++) begin
      if (sensor_enable === 32'h4) hi++;
      tick();
    end
    x = cyc;
    n_tests++;
    if (hi !== 50) begin
      n_fail++;
      $display("FAIL timeout_enable_len: got %0d cycles expected 50", hi);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'hE2) begin
      n_fail++;
      $display("FAIL timeout_hdr: got seen=%0b byte=%02h expected 1/e2", got, b);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'hFF) begin
      n_fail++;
      $display("FAIL timeout_data: got seen=%0b byte=%02h expected 1/ff", got, b);
    end
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_gap_block: got ready=%0b expected 0", req_ready);
    end
    for (int i = 0; i < 40 && req_ready !== 1'b1; i++) tick();
    r = cyc;
    // Gap reloaded to 20 at the exit edge reaches zero 20 edges later.
    n_tests++;
    if (req_ready !== 1'b1 || (r - x) !== 20) begin
      n_fail++;
      $display("FAIL timeout_gap_len: got ready=%0b after %0d cycles expected 1 after 20",
               req_ready, r - x);
    end
  endtask

  task automatic test_invalid();
    logic got, one;
    logic [7:0] b;
    req_valid = 1'b1; req_device = 5'd20; req_command = 8'h77;
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (sensor_enable !== 32'h0 || sensor_request !== 8'h00) begin
      n_fail++;
      $display("FAIL invalid_no_access: got en=%08h req=%02h expected 0/00", sensor_enable, sensor_request);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'hD4) begin
      n_fail++;
      $display("FAIL invalid_hdr: got seen=%0b byte=%02h expected 1/d4", got, b);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h00) begin
      n_fail++;
      $display("FAIL invalid_data: got seen=%0b byte=%02h expected 1/00", got, b);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_no_gap: got ready=%0b expected 1", req_ready);
    end
  endtask

  task automatic test_priority();
    logic got, one;
    logic [7:0] b;
    int x, r;
    auto_device = 5'd1; auto_command = 8'h55; auto_enable = 1'b1;
    // Stay idle long enough that the poll fires while the host waits out a gap.
    repeat (185) tick();
    req_valid = 1'b1; req_device = 5'd3; req_command = 8'h30;
    tick();
    req_valid = 1'b0;
    sensor_finished = 1'b1; sensor_data = 8'h3C;
    tick();
    sensor_finished = 1'b0;
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h03) begin
      n_fail++;
      $display("FAIL prio_pre_hdr: got seen=%0b byte=%02h expected 1/03", got, b);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h3C) begin
      n_fail++;
      $display("FAIL prio_pre_data: got seen=%0b byte=%02h expected 1/3c", got, b);
    end
    req_valid = 1'b1; req_device = 5'd0; req_command = 8'h0A;
    for (int i = 0; i < 60 && sensor_enable === 32'h0; i++) tick();
    req_valid = 1'b0;
    n_tests++;
    if (sensor_enable !== 32'h1 || sensor_request !== 8'h0A) begin
      n_fail++;
      $display("FAIL prio_host_first: got en=%08h req=%02h expected 00000001/0a",
               sensor_enable, sensor_request);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        sensor_finished = 1'b1;
        sensor_data = 8'h33;
      end
      tick();
    end
    sensor_finished = 1'b0;
    x = cyc;
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h00) begin
      n_fail++;
      $display("FAIL prio_host_hdr: got seen=%0b byte=%02h expected 1/00", got, b);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h33) begin
      n_fail++;
      $display("FAIL prio_host_data: got seen=%0b byte=%02h expected 1/33", got, b);
    end
    for (int i = 0; i < 60 && sensor_enable === 32'h0; i++) tick();
    r = cyc;
    // 20 edges for the gap to drain, one more edge for the auto start to register.
    n_tests++;
    if (sensor_enable !== 32'h2 || sensor_request !== 8'h55 || (r - x) !== 21) begin
      n_fail++;
      $display("FAIL prio_auto_start: got en=%08h req=%02h after %0d cycles expected 00000002/55 after 21",
               sensor_enable, sensor_request, r - x);
    end
    sensor_finished = 1'b1; sensor_data = 8'h77;
    tick();
    sensor_finished = 1'b0;
    auto_enable = 1'b0;
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h21) begin
      n_fail++;
      $display("FAIL prio_auto_hdr: got seen=%0b byte=%02h expected 1/21", got, b);
    end
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h77) begin
      n_fail++;
      $display("FAIL prio_auto_data: got seen=%0b byte=%02h expected 1/77", got, b);
    end
  endtask

  task automatic test_tx_busy();
    logic got, one;
    logic [7:0] b;
    int early;
    for (int i = 0; i < 40 && req_ready !== 1'b1; i++) tick();
    tx_busy = 1'b1;
    req_valid = 1'b1; req_device = 5'd1; req_command = 8'h10;
    tick();
    req_valid = 1'b0;
    sensor_finished = 1'b1; sensor_data = 8'h5A;
    tick();
    sensor_finished = 1'b0;
    early = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_valid !== 1'b0) early++;
      tick();
    end
    n_tests++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL busy_hold: got %0d strobes while busy expected 0", early);
    end
    tx_busy = 1'b0;
    tick();
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      n_fail++;
      $display("FAIL busy_release: got txv=%0b txd=%02h expected 1/01", tx_valid, tx_data);
    end
    wait_tx(2, got, b, one);
    wait_tx(10, got, b, one);
    n_tests++;
    if (!got || b !== 8'h5A || !one) begin
      n_fail++;
      $display("FAIL busy_data: got seen=%0b byte=%02h single=%0b expected 1/5a/1", got, b, one);
    end
  endtask

  task automatic test_reset_mid_access();
    int bad;
    for (int i = 0; i < 40 && req_ready !== 1'b1; i++) tick();
    req_valid = 1'b1; req_device = 5'd2; req_command = 8'h22;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (sensor_enable !== 32'h4 || sensor_request !== 8'h22) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got en=%08h req=%02h expected 00000004/22", sensor_enable, sensor_request);
    end
    reset_n = 1'b0;
    tick();
    n_tests++;
    if (sensor_enable !== 32'h0 || sensor_request !== 8'h00 || tx_valid !== 1'b0 ||
        tx_data !== 8'h00 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got en=%08h req=%02h txv=%0b txd=%02h rdy=%0b expected all 0",
               sensor_enable, sensor_request, tx_valid, tx_data, req_ready);
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got %0b expected 1", req_ready);
    end
    tick();
    sensor_finished = 1'b1; sensor_data = 8'h99;
    tick();
    sensor_finished = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b0 || sensor_enable !== 32'h0) bad++;
      tick();
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_stray: got %0d active cycles expected 0", bad);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_device = '0; req_command = '0;
    auto_enable = 1'b0; auto_device = '0; auto_command = '0;
    sensor_finished = 1'b0; sensor_data = '0;
    tx_busy = 1'b0; tx_done = 1'b0;
    tick();
    test_reset();
    test_host_ok();
    test_timeout();
    test_invalid();
    test_priority();
    test_tx_busy();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
